// File: rtl/des_key_sched_ctrl.sv
// DES key-schedule controller: loads a post-PC-1 key and emits the 16 round CD values, one per handshake.
// A single rotating register with registered outputs; the current subkey holds while valid & !ready.
module des_key_sched_ctrl #(
    parameter bit AUTO_ACK = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [55:0] key_in,
    input  logic        abort,
    input  logic        subkey_ready,
    output logic [55:0] subkey,
    output logic        subkey_valid,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t      state, state_nxt;
    logic [55:0] subkey_nxt;
    logic        valid_nxt, busy_nxt, done_nxt, dec_q, dec_nxt;
    logic [3:0]  round_nxt, enc_idx, dec_idx;
    logic        xfer, two;

    function automatic logic [27:0] rotl28(input logic [27:0] v, input logic by2);
        return by2 ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] v, input logic by2);
        return by2 ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
    endfunction

    // Zero-based schedule position; only rounds 1, 2, 9 and 16 shift by one.
    function automatic logic shift_is_two(input logic [3:0] i);
        return !(i == 4'd0 || i == 4'd1 || i == 4'd8 || i == 4'd15);
    endfunction

    assign xfer    = subkey_valid & (subkey_ready | AUTO_ACK);
    assign enc_idx = round_idx + 4'd1;
    assign dec_idx = 4'd15 - round_idx;
    assign two     = dec_q ? shift_is_two(dec_idx) : shift_is_two(enc_idx);

    always_comb begin
        state_nxt  = state;
        subkey_nxt = subkey;
        valid_nxt  = subkey_valid;
        round_nxt  = round_idx;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        dec_nxt    = dec_q;
        if (abort) begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
            round_nxt = 4'd0;
            busy_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt  = ROUND;
                        dec_nxt    = decrypt;
                        // Decrypt begins at K16, whose cumulative shift of 28 is the identity.
                        subkey_nxt = decrypt ? key_in
                                             : {rotl28(key_in[55:28], 1'b0), rotl28(key_in[27:0], 1'b0)};
                        valid_nxt  = 1'b1;
                        round_nxt  = 4'd0;
                        busy_nxt   = 1'b1;
                    end
                end
                ROUND: begin
                    if (xfer) begin
                        if (round_idx == 4'd15) begin
                            state_nxt = DONE;
                            valid_nxt = 1'b0;
                            round_nxt = 4'd0;
                            done_nxt  = 1'b1;
                        end else begin
                            round_nxt  = round_idx + 4'd1;
                            subkey_nxt = dec_q ? {rotr28(subkey[55:28], two), rotr28(subkey[27:0], two)}
                                               : {rotl28(subkey[55:28], two), rotl28(subkey[27:0], two)};
                        end
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end
                default: begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                    round_nxt = 4'd0;
                    busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            subkey       <= '0;
            subkey_valid <= 1'b0;
            round_idx    <= 4'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            dec_q        <= 1'b0;
        end else begin
            state        <= state_nxt;
            subkey       <= subkey_nxt;
            subkey_valid <= valid_nxt;
            round_idx    <= round_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            dec_q        <= dec_nxt;
        end
    end

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Bench for des_key_sched_ctrl: directed and randomized sessions against a cumulative-shift key model.
module tb_des_key_sched_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        decrypt = 1'b0;
    logic [55:0] key_in = '0;
    logic        abort = 1'b0;
    logic        subkey_ready = 1'b0;
    logic [55:0] subkey;
    logic        subkey_valid;
    logic [3:0]  round_idx;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;
    int s_tab[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    int pat[6]    = '{1, 0, 0, 1, 0, 1};

    localparam logic [55:0] KEY_A = 56'hF0CCAAF556678F;

    des_key_sched_ctrl #(.AUTO_ACK(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .key_in(key_in),
        .abort(abort), .subkey_ready(subkey_ready), .subkey(subkey),
        .subkey_valid(subkey_valid), .round_idx(round_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [27:0] rotl(input logic [27:0] v, input int n);
        logic [55:0] t;
        t = {v, v};
        return t[55-n -: 28];
    endfunction

    // Expected output sequence: round r carries the total shift of rounds 1..r, mod 28.
    task automatic build_exp(input logic [55:0] k, input logic d, output logic [55:0] e[16]);
        logic [55:0] enc[16];
        int cum;
        cum = 0;
        for (int r = 0; r < 16; r++) begin
            cum += s_tab[r];
            enc[r] = {rotl(k[55:28], cum % 28), rotl(k[27:0], cum % 28)};
        end
        for (int n = 0; n < 16; n++) e[n] = d ? enc[15-n] : enc[n];
    endtask

    // mode 0: ready held 1; mode 1: ready pattern 1,0,0,1,0,1; mode 2: random ready.
    task automatic session(input logic [55:0] k, input logic d, input int mode, input int glitch_at);
        logic [55:0] e[16];
        logic [63:0] junk;
        int n, cyc, r;
        bit glitched;
        build_exp(k, d, e);
        start = 1'b1; key_in = k; decrypt = d;
        step();
        start = 1'b0;
        junk = {$urandom(), $urandom()};
        key_in = junk[55:0];
        n = 0; cyc = 0; glitched = 0;
        while (n < 16 && cyc < 400) begin
            chk("valid", {63'd0, subkey_valid}, 64'd1);
            chk("round_idx", {60'd0, round_idx}, n);
            chk("subkey", {8'd0, subkey}, {8'd0, e[n]});
            chk("busy_round", {63'd0, busy}, 64'd1);
            if (glitch_at == n && !glitched) begin
                start = 1'b1; key_in = ~k; decrypt = ~d; glitched = 1;
            end else begin
                start = 1'b0;
            end
            r = (mode == 0) ? 1 : (mode == 1) ? pat[cyc % 6] : int'($urandom_range(0, 1));
            subkey_ready = r[0];
            step();
            if (r != 0) n++;
            cyc++;
        end
        start = 1'b0;
        subkey_ready = 1'b0;
        chk("no_timeout", {63'd0, cyc < 400}, 64'd1);
        chk("done_pulse", {63'd0, done}, 64'd1);
        chk("busy_done", {63'd0, busy}, 64'd1);
        chk("valid_done", {63'd0, subkey_valid}, 64'd0);
        chk("subkey_hold", {8'd0, subkey}, {8'd0, e[15]});
        step();
        chk("done_clear", {63'd0, done}, 64'd0);
        chk("busy_idle", {63'd0, busy}, 64'd0);
        chk("round_idle", {60'd0, round_idx}, 64'd0);
    endtask

    initial begin
        logic [63:0] r64;
        #2;
        chk("rst_subkey", {8'd0, subkey}, 64'd0);
        chk("rst_valid", {63'd0, subkey_valid}, 64'd0);
        chk("rst_round", {60'd0, round_idx}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        #21 rst_n = 1'b1;
        step();

        // Known-answer: first and last encrypt subkeys.
        start = 1'b1; key_in = KEY_A; decrypt = 1'b0; subkey_ready = 1'b1;
        step();
        start = 1'b0;
        chk("kat_enc_k1", {8'd0, subkey}, {8'd0, 56'hE19955FAACCF1E});
        for (int i = 0; i < 15; i++) step();
        chk("kat_enc_round15", {60'd0, round_idx}, 64'd15);
        chk("kat_enc_k16", {8'd0, subkey}, {8'd0, KEY_A});
        step();
        subkey_ready = 1'b0;
        chk("kat_done_T17", {63'd0, done}, 64'd1);
        step();
        chk("kat_busy_T18", {63'd0, busy}, 64'd0);

        // Known-answer decrypt, started in the T+18 cycle.
        start = 1'b1; decrypt = 1'b1; subkey_ready = 1'b1;
        step();
        start = 1'b0;
        chk("kat_dec_k16", {8'd0, subkey}, {8'd0, KEY_A});
        step();
        chk("kat_dec_k15", {8'd0, subkey}, {8'd0, 56'hF866557AAB33C7});
        subkey_ready = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;

        session(KEY_A, 1'b0, 0, -1);
        session(KEY_A, 1'b1, 0, -1);
        session(KEY_A, 1'b0, 1, -1);
        session(KEY_A, 1'b0, 0, 7);
        session(KEY_A, 1'b1, 2, 3);

        // Abort at round 5 with a concurrent transfer.
        start = 1'b1; key_in = KEY_A; decrypt = 1'b0; subkey_ready = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("abort_at5", {60'd0, round_idx}, 64'd5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        subkey_ready = 1'b0;
        chk("abort_valid", {63'd0, subkey_valid}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_round", {60'd0, round_idx}, 64'd0);
        chk("abort_nodone", {63'd0, done}, 64'd0);
        step();
        chk("abort_nodone2", {63'd0, done}, 64'd0);
        session(56'd0, 1'b0, 0, -1);

        // Abort and start together in IDLE: start dropped.
        abort = 1'b1; start = 1'b1; key_in = KEY_A;
        step();
        abort = 1'b0; start = 1'b0;
        chk("abort_start_busy", {63'd0, busy}, 64'd0);
        chk("abort_start_valid", {63'd0, subkey_valid}, 64'd0);

        for (int t = 0; t < 4; t++) begin
            r64 = {$urandom(), $urandom()};
            session(r64[55:0], 1'($urandom_range(0, 1)), 2, -1);
        end

        // Asynchronous reset between edges mid-ROUND.
        start = 1'b1; key_in = KEY_A; decrypt = 1'b0; subkey_ready = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_subkey", {8'd0, subkey}, 64'd0);
        chk("arst_valid", {63'd0, subkey_valid}, 64'd0);
        chk("arst_round", {60'd0, round_idx}, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        #10 rst_n = 1'b1;
        subkey_ready = 1'b0;
        step(); step(); step();
        chk("post_rst_idle", {63'd0, busy}, 64'd0);
        chk("post_rst_valid", {63'd0, subkey_valid}, 64'd0);
        session(KEY_A, 1'b1, 1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
